// File: rtl/bram_loader.sv
// bram_loader
// Stages pipe-endpoint words into full-width BRAM lines. Each line holds
// BURST_LEN fp16 elements. Completed lines go to an auto-incrementing write
// address. The block counts committed lines, raises done at a nonzero line
// limit, and flags words that arrive after done.
//
// Ports
//   clk, rst_n         rising-edge clock, async active-low reset
//   clear_i            synchronous clear, same effect as reset, highest priority
//   pack_mode_i        0: one element per word, 1: two elements ([15:0] first)
//   line_limit_i       expected line count, 0 = unlimited
//   flush_i            commit the partial line zero-padded (pulse)
//   in_valid_i/in_data_i  pipe write strobe and data
//   ram_wr_en_o/ram_addr_o/ram_data_o  registered BRAM write port
//   lines_written_o    lines committed since clear (saturating)
//   done_o             sticky, lines_written reached a nonzero line_limit
//   overflow_o         sticky, a word arrived while done was set
module bram_loader #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_i,
  input  logic                        pack_mode_i,
  input  logic [ADDR_W:0]             line_limit_i,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  input  logic [31:0]                 in_data_i,
  output logic                        ram_wr_en_o,
  output logic [ADDR_W-1:0]           ram_addr_o,
  output logic [DATA_W*BURST_LEN-1:0] ram_data_o,
  output logic [ADDR_W:0]             lines_written_o,
  output logic                        done_o,
  output logic                        overflow_o
);

  localparam int CNT_W = $clog2(BURST_LEN);

  typedef logic [BURST_LEN-1:0][DATA_W-1:0] line_t;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_hi;
  logic [CNT_W:0]    cnt_sum;
  line_t             pack_q, pack_d;
  line_t             line_w;
  logic              carry_v;
  logic              commit;
  logic              accept;
  logic [DATA_W-1:0] elem_lo, elem_hi;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   lines_q, lines_d;
  logic              done_q, overflow_q;
  logic              ram_wr_en_q;
  logic [ADDR_W-1:0] ram_addr_q;
  line_t             ram_data_q;

  assign accept  = in_valid_i & ~done_q;
  assign elem_lo = in_data_i[DATA_W-1:0];
  assign elem_hi = in_data_i[16 +: DATA_W];
  assign idx_hi  = count_q + CNT_W'(1);

  // Unfilled lanes of pack_q are always zero (cleared on every commit), so a
  // flushed line comes out zero-padded without extra masking.
  always_comb begin
    line_w  = pack_q;
    cnt_sum = {1'b0, count_q};
    carry_v = 1'b0;
    if (accept) begin
      line_w[count_q] = elem_lo;
      if (!pack_mode_i) begin
        cnt_sum = {1'b0, count_q} + (CNT_W+1)'(1);
      end else if (count_q == CNT_W'(BURST_LEN-1)) begin
        // low half closes the line, high half spills into lane 0 of the next
        carry_v = 1'b1;
        cnt_sum = (CNT_W+1)'(BURST_LEN);
      end else begin
        line_w[idx_hi] = elem_hi;
        cnt_sum = {1'b0, count_q} + (CNT_W+1)'(2);
      end
    end
  end

  // A word-completed line and a flush can never produce two writes in one
  // cycle: the flush only acts when the word did not already commit.
  always_comb begin
    commit = 1'b0;
    if (cnt_sum == (CNT_W+1)'(BURST_LEN)) begin
      commit = 1'b1;
    end else if (flush_i && !done_q && (cnt_sum != '0)) begin
      commit = 1'b1;
    end
  end

  always_comb begin
    pack_d  = line_w;
    count_d = cnt_sum[CNT_W-1:0];
    if (commit) begin
      pack_d  = '0;
      count_d = '0;
      if (carry_v) begin
        pack_d[0] = elem_hi;
        count_d   = CNT_W'(1);
      end
    end
  end

  assign lines_d = (lines_q == '1) ? lines_q : lines_q + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      pack_q      <= '0;
      addr_q      <= '0;
      lines_q     <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      ram_wr_en_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else if (clear_i) begin
      count_q     <= '0;
      pack_q      <= '0;
      addr_q      <= '0;
      lines_q     <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      ram_wr_en_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      pack_q      <= pack_d;
      ram_wr_en_q <= commit;
      if (commit) begin
        ram_addr_q <= addr_q;
        ram_data_q <= line_w;
        addr_q     <= addr_q + ADDR_W'(1);
        lines_q    <= lines_d;
        if ((line_limit_i != '0) && (lines_d == line_limit_i)) begin
          done_q <= 1'b1;
        end
      end
      if (in_valid_i && done_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign ram_wr_en_o     = ram_wr_en_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_data_o      = ram_data_q;
  assign lines_written_o = lines_q;
  assign done_o          = done_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_bram_loader.sv
// Testbench for bram_loader (BURST_LEN=8, ADDR_W=3 so address wrap and
// lines_written saturation are reachable quickly).
module tb_bram_loader;

  localparam int BL = 8;
  localparam int AW = 3;
  localparam int DW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear = 1'b0;
  logic           pack_mode = 1'b0;
  logic [AW:0]    line_limit = '0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic [31:0]    in_data = '0;
  logic           ram_wr_en;
  logic [AW-1:0]  ram_addr;
  logic [DW*BL-1:0] ram_data;
  logic [AW:0]    lines_written;
  logic           done;
  logic           overflow;

  bram_loader #(.BURST_LEN(BL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear_i         (clear),
    .pack_mode_i     (pack_mode),
    .line_limit_i    (line_limit),
    .flush_i         (flush),
    .in_valid_i      (in_valid),
    .in_data_i       (in_data),
    .ram_wr_en_o     (ram_wr_en),
    .ram_addr_o      (ram_addr),
    .ram_data_o      (ram_data),
    .lines_written_o (lines_written),
    .done_o          (done),
    .overflow_o      (overflow)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int             cyc;
    logic [AW-1:0]  addr;
    logic [DW*BL-1:0] data;
    logic [AW:0]    lines;
    logic           done;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: current line as a list of elements plus counters.
  int m_lanes[$];
  int m_addr  = 0;
  int m_lines = 0;
  bit m_done  = 0;
  bit m_ovf   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lanes.delete();
    m_addr  = 0;
    m_lines = 0;
    m_done  = 0;
    m_ovf   = 0;
  endtask

  task automatic model_commit();
    exp_t e;
    e.cyc  = cyc_n + 1;
    e.addr = m_addr[AW-1:0];
    e.data = '0;
    for (int k = 0; k < m_lanes.size(); k++) begin
      int v;
      v = m_lanes[k];
      e.data[16*k +: 16] = v[15:0];
    end
    m_addr = (m_addr + 1) % (1 << AW);
    if (m_lines < (1 << (AW+1)) - 1) m_lines++;
    if (line_limit != 0 && m_lines == int'(line_limit)) m_done = 1;
    e.lines = m_lines[AW:0];
    e.done  = m_done;
    sbq.push_back(e);
    m_lanes.delete();
  endtask

  task automatic model_step(input bit v, input bit mode, input logic [31:0] d, input bit fl);
    bit com;
    com = 0;
    if (v) begin
      if (m_done) m_ovf = 1;
      else begin
        m_lanes.push_back(int'(d[15:0]));
        if (m_lanes.size() == BL) begin model_commit(); com = 1; end
        if (mode) begin
          m_lanes.push_back(int'(d[31:16]));
          if (m_lanes.size() == BL) begin model_commit(); com = 1; end
        end
      end
    end
    if (fl && !m_done && !com && m_lanes.size() > 0) model_commit();
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes the BRAM.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc_n) begin
        checks++; errors++;
        $display("FAIL missing_write: got none expected addr %0d at cycle %0d", sbq[0].addr, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (ram_wr_en) begin
        if (sbq.size() == 0 || sbq[0].cyc != cyc_n) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0d data %h at cycle %0d expected no write", ram_addr, ram_data, cyc_n);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("wr_addr", ram_addr, e.addr);
          chk("wr_data", ram_data, e.data);
          chk("wr_lines", lines_written, e.lines);
          chk("wr_done", done, e.done);
        end
      end
    end
  end

  task automatic cyc(input bit v, input bit mode, input logic [31:0] d, input bit fl);
    in_valid  = v;
    pack_mode = mode;
    in_data   = d;
    flush     = fl;
    model_step(v, mode, d, fl);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("lines_written", lines_written, m_lines[AW:0]);
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, ram_wr_en, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_data"}, ram_data, 0);
    chk({tag, "_lines"}, lines_written, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    model_reset();
    @(posedge clk); #1;
    clear = 1'b0;
    check_zero("clear");
  endtask

  // Called one cycle after the last activity so no write is in flight.
  task automatic do_async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_zero("rst");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode 0, one full line
    line_limit = 0;
    for (int i = 1; i <= 8; i++) cyc(1, 0, i, 0);
    cyc(0, 0, 0, 0);
    chk("t1_lines", lines_written, 1);

    // Mode 1, two lines, commits 4 cycles apart
    do_clear();
    for (int i = 0; i < 8; i++) cyc(1, 1, {16'(2*i+2), 16'(2*i+1)}, 0);
    cyc(0, 0, 0, 0);

    // Flush partial line, then a flush with nothing pending
    do_clear();
    cyc(1, 0, 32'hA, 0);
    cyc(1, 0, 32'hB, 0);
    cyc(1, 0, 32'hC, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Limit 2 and overflow
    do_clear();
    line_limit = 2;
    for (int i = 1; i <= 17; i++) cyc(1, 0, 32'h100 + i, 0);
    cyc(0, 0, 0, 1);
    chk("t4_done", done, 1);
    chk("t4_ovf", overflow, 1);
    chk("t4_lines", lines_written, 2);

    // Unlimited: address wraps, then lines_written saturates
    do_clear();
    line_limit = 0;
    for (int i = 0; i < 72; i++) cyc(1, 0, 32'h200 + i, 0);
    cyc(0, 0, 0, 0);
    chk("t5_lines", lines_written, 9);
    chk("t5_done", done, 0);
    for (int i = 0; i < 56; i++) cyc(1, 0, 32'h300 + i, 0);
    cyc(0, 0, 0, 0);
    chk("t5_sat", lines_written, 15);

    // Async reset mid-line, then a fresh line at address 0
    do_clear();
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'h400 + i, 0);
    cyc(0, 0, 0, 0);
    do_async_reset();
    for (int i = 0; i < 8; i++) cyc(1, 0, 32'h500 + i, 0);
    cyc(0, 0, 0, 0);

    // Clear mid-line
    for (int i = 0; i < 3; i++) cyc(1, 1, $urandom, 0);
    do_clear();
    for (int i = 0; i < 8; i++) cyc(1, 0, 32'h600 + i, 0);

    // Flush together with the completing word: exactly one write
    for (int i = 0; i < 7; i++) cyc(1, 0, 32'h700 + i, 0);
    cyc(1, 0, 32'h707, 1);
    cyc(0, 0, 0, 0);

    // Mode 1 at the last lane with flush: one write, spill survives, next flush pads it
    for (int i = 0; i < 7; i++) cyc(1, 0, 32'h800 + i, 0);
    cyc(1, 1, 32'hBEEF_0807, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Randomised segments with assorted limits
    for (int s = 0; s < 4; s++) begin
      do_clear();
      case (s)
        0: line_limit = 0;
        1: line_limit = 3;
        2: line_limit = 5;
        default: line_limit = 15;
      endcase
      for (int n = 0; n < 150; n++) begin
        if (s == 2 && n == 75) line_limit = 9;
        cyc($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 19) == 0);
      end
      cyc(0, 0, 0, 0);
    end

    repeat (3) cyc(0, 0, 0, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
